// File: rtl/north_mem_pkg.sv
// Shared types and defaults for the north memory responder.
// The FSM encoding is visible on state_out, so the values are fixed here.
package north_mem_pkg;

    localparam int ADDR_W_DEF      = 10;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/north_mem_ram.sv
// Single-port synchronous store for the north memory responder.
// Contents are deliberately not reset, so stored data survives a reset.
module north_mem_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // A single access per edge: either write the location or register its contents.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/north_mem_responder.sv
// North-side memory responder: accepts level read/write strobes, stays busy
// for WAIT_CYCLES cycles, then presents data_north/mem_err for one DONE cycle.
// Optional feature: define NORTH_MEM_PARITY_EN to widen the store to 17 bits
// with an even-parity bit per halfword, checked on reads.
//
// state | meaning
// IDLE  | ready; a read or write strobe is accepted at the next edge
// BUSY  | access in flight, down-counter running, mem_rdy low
// DONE  | one cycle with result valid; strobes ignored, returns to IDLE
module north_mem_responder
    import north_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [15:0] wr_data,
    input  logic        mem_read_north,
    input  logic        mem_write_north,
    output logic [15:0] data_north,
    output logic        mem_rdy,
    output logic        mem_err,
    output logic [1:0]  state_out
);

`ifdef NORTH_MEM_PARITY_EN
    localparam int DATA_W = 17;
`else
    localparam int DATA_W = 16;
`endif

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic [24:0]         addr_q;
    logic [15:0]         wdata_q;
    logic                rd_q;
    logic                wr_q;
    logic [15:0]         data_q;
    logic                err_q;

    logic                accept;
    logic                finish;
    logic                ram_en;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;
    logic                oor;
    logic                illegal;
    logic                rd_err;

    // Bits above 24 take no part in decode.
    logic                unused_addr;
    assign unused_addr = ^addr[31:25];

    // Bit 24 or anything between the index and bit 24 makes the access out of range.
    assign oor     = addr_q[24] | ((addr_q[23:0] >> ADDR_W) != 24'd0);
    assign illegal = rd_q & wr_q;

`ifdef NORTH_MEM_PARITY_EN
    assign ram_wdata = {^wdata_q, wdata_q};
    assign rd_err    = (^ram_rdata[15:0]) != ram_rdata[16];
`else
    assign ram_wdata = wdata_q;
    assign rd_err    = 1'b0;
`endif

    // Next state and store control; the store is read at acceptance so the
    // data is already sitting on ram_rdata by the edge that leaves BUSY.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        finish   = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr_q[ADDR_W-1:0];
        case (state_q)
            IDLE: begin
                ram_addr = addr[ADDR_W-1:0];
                if (mem_read_north || mem_write_north) begin
                    accept  = 1'b1;
                    ram_en  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    finish  = 1'b1;
                    state_d = DONE;
                    if (wr_q && !rd_q && !oor) begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Busy-cycle down-counter: loaded on acceptance, terminal count ends BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= 4'(WAIT_CYCLES);
        end else if (finish) begin
            cnt_q <= 4'd0;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Capture the request at acceptance; it stays stable for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= addr[24:0];
            wdata_q <= wr_data;
            rd_q    <= mem_read_north;
            wr_q    <= mem_write_north;
        end
    end

    // Result registers: updated only at the edge leaving BUSY; error lasts one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (finish) begin
                if (illegal) begin
                    data_q <= 16'h0000;
                    err_q  <= 1'b1;
                end else if (rd_q) begin
                    if (oor) begin
                        data_q <= 16'h0000;
                        err_q  <= 1'b1;
                    end else begin
                        data_q <= ram_rdata[15:0];
                        err_q  <= rd_err;
                    end
                end else begin
                    err_q <= oor;
                end
            end
        end
    end

    assign data_north = data_q;
    assign mem_err    = err_q;
    assign mem_rdy    = (state_q != BUSY);
    assign state_out  = state_q;

    north_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_north_mem_responder.sv
// Directed bench for north_mem_responder with default parameters
// (ADDR_W=10, WAIT_CYCLES=2). Inputs change and outputs are sampled on the
// falling edge of clk.
module tb_north_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [15:0] wr_data;
    logic        mem_read_north;
    logic        mem_write_north;
    logic [15:0] data_north;
    logic        mem_rdy;
    logic        mem_err;
    logic [1:0]  state_out;

    int total = 0;
    int bad   = 0;

    north_mem_responder dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .wr_data         (wr_data),
        .mem_read_north  (mem_read_north),
        .mem_write_north (mem_write_north),
        .data_north      (data_north),
        .mem_rdy         (mem_rdy),
        .mem_err         (mem_err),
        .state_out       (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete access starting at a falling edge; checks every cycle of it.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [15:0] d, input logic [15:0] exp_d,
                          input logic exp_e, input string tag);
        mem_read_north  = rd;
        mem_write_north = wr;
        addr            = a;
        wr_data         = d;
        @(negedge clk);
        chk({tag, "_busy1_state"}, 32'(state_out), 32'd1);
        chk({tag, "_busy1_rdy"}, 32'(mem_rdy), 32'd0);
        chk({tag, "_busy1_err"}, 32'(mem_err), 32'd0);
        mem_read_north  = 1'b0;
        mem_write_north = 1'b0;
        @(negedge clk);
        chk({tag, "_busy2_rdy"}, 32'(mem_rdy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_state"}, 32'(state_out), 32'd2);
        chk({tag, "_done_rdy"}, 32'(mem_rdy), 32'd1);
        chk({tag, "_done_err"}, 32'(mem_err), 32'(exp_e));
        chk({tag, "_done_data"}, 32'(data_north), 32'(exp_d));
        @(negedge clk);
        chk({tag, "_idle_state"}, 32'(state_out), 32'd0);
        chk({tag, "_idle_err"}, 32'(mem_err), 32'd0);
    endtask

    initial begin
        rst             = 1'b0;
        addr            = '0;
        wr_data         = '0;
        mem_read_north  = 1'b0;
        mem_write_north = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_rdy", 32'(mem_rdy), 32'd1);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_data", 32'(data_north), 32'h0);

        // Release reset with a write already pending: accepted on the first edge.
        rst = 1'b1;
        access(1'b0, 1'b1, 32'h0000_0005, 16'hBEEF, 16'h0000, 1'b0, "wr_beef");
        access(1'b1, 1'b0, 32'h0000_0005, 16'h0000, 16'hBEEF, 1'b0, "rd_beef");

        // Back-to-back reads with the strobe held high.
        access(1'b0, 1'b1, 32'h0000_0010, 16'h1234, 16'hBEEF, 1'b0, "wr_10");
        access(1'b0, 1'b1, 32'h0000_0011, 16'h5678, 16'hBEEF, 1'b0, "wr_11");
        mem_read_north = 1'b1;
        addr           = 32'h0000_0010;
        @(negedge clk);
        chk("strm_a_busy", 32'(state_out), 32'd1);
        addr = 32'h0000_0011;
        @(negedge clk);
        chk("strm_a_busy2_rdy", 32'(mem_rdy), 32'd0);
        @(negedge clk);
        chk("strm_a_done", 32'(state_out), 32'd2);
        chk("strm_a_data", 32'(data_north), 32'h1234);
        chk("strm_a_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        chk("strm_gap_state", 32'(state_out), 32'd0);
        chk("strm_gap_rdy", 32'(mem_rdy), 32'd1);
        chk("strm_gap_data_hold", 32'(data_north), 32'h1234);
        @(negedge clk);
        chk("strm_b_busy", 32'(state_out), 32'd1);
        chk("strm_b_rdy", 32'(mem_rdy), 32'd0);
        @(negedge clk);
        chk("strm_b_busy2", 32'(state_out), 32'd1);
        @(negedge clk);
        chk("strm_b_done", 32'(state_out), 32'd2);
        chk("strm_b_data", 32'(data_north), 32'h5678);
        mem_read_north = 1'b0;
        @(negedge clk);
        chk("strm_end_idle", 32'(state_out), 32'd0);
        @(negedge clk);
        chk("strm_no_extra", 32'(state_out), 32'd0);

        // Out-of-range accesses.
        access(1'b0, 1'b1, 32'h0000_0000, 16'h0F0F, 16'h5678, 1'b0, "wr_0");
        access(1'b1, 1'b0, 32'h0100_0003, 16'h0000, 16'h0000, 1'b1, "rd_oor");
        access(1'b0, 1'b1, 32'h0000_0400, 16'hDEAD, 16'h0000, 1'b1, "wr_oor");
        access(1'b1, 1'b0, 32'h0000_0000, 16'h0000, 16'h0F0F, 1'b0, "rd_0");

        // Both strobes at once.
        access(1'b0, 1'b1, 32'h0000_0007, 16'h7777, 16'h0F0F, 1'b0, "wr_7");
        access(1'b1, 1'b0, 32'h0000_0007, 16'h0000, 16'h7777, 1'b0, "rd_7a");
        access(1'b1, 1'b1, 32'h0000_0007, 16'h1111, 16'h0000, 1'b1, "both_7");
        access(1'b1, 1'b0, 32'h0000_0007, 16'h0000, 16'h7777, 1'b0, "rd_7b");

        // Reset in the middle of a write aborts it.
        access(1'b0, 1'b1, 32'h0000_0003, 16'h3333, 16'h7777, 1'b0, "wr_3");
        mem_write_north = 1'b1;
        addr            = 32'h0000_0003;
        wr_data         = 16'hAAAA;
        @(negedge clk);
        chk("abort_busy", 32'(state_out), 32'd1);
        mem_write_north = 1'b0;
        rst             = 1'b0;
        #1;
        chk("abort_rdy", 32'(mem_rdy), 32'd1);
        chk("abort_state", 32'(state_out), 32'd0);
        chk("abort_data", 32'(data_north), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 32'h0000_0003, 16'h0000, 16'h3333, 1'b0, "rd_3");

`ifdef NORTH_MEM_PARITY_EN
        access(1'b0, 1'b1, 32'h0000_0002, 16'h0001, 16'h3333, 1'b0, "wr_par");
        dut.u_ram.mem[2][16] = ~dut.u_ram.mem[2][16];
        access(1'b1, 1'b0, 32'h0000_0002, 16'h0000, 16'h0001, 1'b1, "rd_par");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
